// File: rtl/sys_ctrl_tx_packer_pkg.sv
// sys_ctrl_tx_packer_pkg: shared SYS_CTRL state encoding and width defaults
package sys_ctrl_tx_packer_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_FIRST  = 2'd1,
    SEND_SECOND = 2'd2
  } state_e;
endpackage

// File: rtl/sys_ctrl_tx_packer_if.sv
// sys_ctrl_tx_packer_if: result input, FIFO write port and error flag bundle
interface sys_ctrl_tx_packer_if
  import sys_ctrl_tx_packer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic [2*DATA_WIDTH-1:0] res_data;
  logic                    res_valid;
  logic                    res_two_byte;
  logic                    res_ready;
  logic                    fifo_full;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    wr_inc;
  logic                    busy;
  logic                    err_overrun;
  logic                    err_clr;
  modport master (
    output res_data, res_valid, res_two_byte, fifo_full, err_clr,
    input  res_ready, wr_data, wr_inc, busy, err_overrun
  );
  modport slave (
    input  res_data, res_valid, res_two_byte, fifo_full, err_clr,
    output res_ready, wr_data, wr_inc, busy, err_overrun
  );
endinterface

// File: rtl/sys_ctrl_tx_packer.sv
// sys_ctrl_tx_packer: splits a one- or two-byte result into FIFO writes with back-pressure
module sys_ctrl_tx_packer
  import sys_ctrl_tx_packer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter bit LSB_FIRST  = 1'b1
) (
  input logic                CLK,
  input logic                RST,
  sys_ctrl_tx_packer_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  state_e            state_q, state_d;
  logic [2*DW-1:0]   hold_q, hold_d;
  logic              two_q, two_d;
  logic              err_q, err_d;
  logic [DW-1:0]     lo, hi, sel;
  logic              send, wr, accept;
  assign lo = hold_q[DW-1:0];
  assign hi = hold_q[2*DW-1:DW];
  always_comb begin
    send    = state_q != IDLE;
    wr      = !RST && send && !bus.fifo_full;
    accept  = state_q == IDLE && bus.res_valid;
    sel     = state_q == SEND_SECOND ? (LSB_FIRST ? hi : lo) : (two_q && !LSB_FIRST ? hi : lo);
    state_d = accept ? SEND_FIRST :
              wr     ? (state_q == SEND_FIRST && two_q ? SEND_SECOND : IDLE) : state_q;
    hold_d  = accept ? bus.res_data : hold_q;
    two_d   = accept ? bus.res_two_byte : two_q;
    // a new overrun outranks a simultaneous clear
    err_d   = (bus.res_valid && send) || (err_q && !bus.err_clr);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      hold_q  <= '0;
      two_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      two_q   <= two_d;
      err_q   <= err_d;
    end
  end
  assign bus.res_ready   = RST || state_q == IDLE;
  assign bus.busy        = !(RST || state_q == IDLE);
  assign bus.wr_inc      = wr;
  assign bus.wr_data     = wr ? sel : '0;
  assign bus.err_overrun = err_q;
endmodule

// File: tb/tb_sys_ctrl_tx_packer.sv
// tb_sys_ctrl_tx_packer: queue-model check of both byte orders under random traffic
module tb_sys_ctrl_tx_packer;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic          valid = 1'b0, two = 1'b0, full = 1'b0, clr = 1'b0;
  logic [15:0]   data = '0;
  int ncmp = 0, nerr = 0;
  logic [7:0] q[2][$];
  logic [7:0] lg[2][$];
  bit         merr[2];
  always #5 clk = ~clk;
  sys_ctrl_tx_packer_if #(.DATA_WIDTH(DW)) b0 ();
  sys_ctrl_tx_packer_if #(.DATA_WIDTH(DW)) b1 ();
  assign b0.res_data = data;  assign b1.res_data = data;
  assign b0.res_valid = valid; assign b1.res_valid = valid;
  assign b0.res_two_byte = two; assign b1.res_two_byte = two;
  assign b0.fifo_full = full; assign b1.fifo_full = full;
  assign b0.err_clr = clr;    assign b1.err_clr = clr;
  sys_ctrl_tx_packer #(.DATA_WIDTH(DW), .LSB_FIRST(1'b1)) u0 (.CLK(clk), .RST(rst), .bus(b0.slave));
  sys_ctrl_tx_packer #(.DATA_WIDTH(DW), .LSB_FIRST(1'b0)) u1 (.CLK(clk), .RST(rst), .bus(b1.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string nm, input int i, input logic [7:0] exp[$]);
    chk({nm, "_len"}, lg[i].size(), exp.size());
    for (int k = 0; k < exp.size() && k < lg[i].size(); k++) chk(nm, lg[i][k], exp[k]);
  endtask

  task automatic step();
    logic       ry, bz, wi, eo, ew;
    logic [7:0] wd;
    bit         empty;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      ry = i ? b1.res_ready : b0.res_ready;
      bz = i ? b1.busy : b0.busy;
      wi = i ? b1.wr_inc : b0.wr_inc;
      wd = i ? b1.wr_data : b0.wr_data;
      eo = i ? b1.err_overrun : b0.err_overrun;
      ew = !rst && q[i].size() > 0 && !full;
      chk($sformatf("res_ready%0d", i), ry, rst || q[i].size() == 0);
      chk($sformatf("busy%0d", i), bz, !rst && q[i].size() != 0);
      chk($sformatf("wr_inc%0d", i), wi, ew);
      chk($sformatf("wr_data%0d", i), wd, ew ? q[i][0] : 8'h00);
      chk($sformatf("err_overrun%0d", i), eo, merr[i]);
      if (wi === 1'b1) lg[i].push_back(wd);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        q[i].delete();
        merr[i] = 1'b0;
      end else begin
        empty = q[i].size() == 0;
        if (valid && !empty) merr[i] = 1'b1;
        else if (clr) merr[i] = 1'b0;
        if (!empty && !full) void'(q[i].pop_front());
        if (valid && empty) begin
          if (!two) q[i].push_back(data[7:0]);
          else if (i == 0) begin q[i].push_back(data[7:0]); q[i].push_back(data[15:8]); end
          else begin q[i].push_back(data[15:8]); q[i].push_back(data[7:0]); end
        end
      end
    end
    #1;
  endtask

  task automatic apply(input logic v, input logic t, input logic [15:0] d, input logic f, input logic c);
    valid = v; two = t; data = d; full = f; clr = c;
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic clr_logs();
    lg[0].delete();
    lg[1].delete();
  endtask

  initial begin
    @(posedge clk); #1;
    step();
    rst = 1'b0;
    chk("reset_ready", b0.res_ready, 1'b1);
    chk("reset_err", b0.err_overrun, 1'b0);
    idle(2);
    // two-byte, both orders
    clr_logs();
    apply(1'b1, 1'b1, 16'hA55A, 1'b0, 1'b0);
    idle(2);
    chk("t1_ready_n3", b0.res_ready, 1'b1);
    chk_log("t1_lsb", 0, '{8'h5A, 8'hA5});
    chk_log("t1_msb", 1, '{8'hA5, 8'h5A});
    idle(1);
    // one-byte
    clr_logs();
    apply(1'b1, 1'b0, 16'h00C3, 1'b0, 1'b0);
    idle(1);
    chk("t2_ready_n2", b0.res_ready, 1'b1);
    chk_log("t2_lsb", 0, '{8'hC3});
    chk_log("t2_msb", 1, '{8'hC3});
    // back-pressure
    clr_logs();
    apply(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) apply(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    idle(3);
    chk_log("t3_lsb", 0, '{8'h34, 8'h12});
    // overrun, clear, clear-vs-set
    clr_logs();
    apply(1'b1, 1'b1, 16'h3344, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 16'h5566, 1'b0, 1'b0);
    chk("t4_err_set", b0.err_overrun, 1'b1);
    idle(2);
    chk_log("t4_lsb", 0, '{8'h44, 8'h33});
    apply(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("t4_err_clr", b0.err_overrun, 1'b0);
    apply(1'b1, 1'b0, 16'h0077, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 16'h0088, 1'b1, 1'b1);
    chk("t4_set_wins", b0.err_overrun, 1'b1);
    idle(2);
    apply(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    // MSB-first ordering
    clr_logs();
    apply(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    idle(3);
    chk_log("t5_msb", 1, '{8'hBE, 8'hEF});
    // reset between bytes
    clr_logs();
    apply(1'b1, 1'b1, 16'hABCD, 1'b0, 1'b0);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);
    chk_log("t6_lsb", 0, '{8'hCD});
    chk("t6_ready", b0.res_ready, 1'b1);
    chk("t6_err", b0.err_overrun, 1'b0);
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom % 200) == 0;
      apply(($urandom % 3) == 0, 1'($urandom), 16'($urandom), ($urandom % 4) == 0, ($urandom % 16) == 0);
    end
    rst = 1'b0;
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end
endmodule
